// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage encodings: result-select codes, load funct3 values
// and the MEM/WB pipeline register layout.
package wb_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        result_src;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus_4;
  } memwb_t;

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/half addressed by addr[1:0] out of the
// raw memory word, sign/zero-extends it, and flags misaligned half/word loads.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

  // Unknown load funct3 falls through to the raw word.
  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

  assign misaligned_o = (is_half(funct3_i) && addr_i[0]) ||
                        ((funct3_i == F3_LW) && (addr_i != 2'b00));

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, result select, register-file write
// port, forwarding copy and retire / misaligned-load counters.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_m,
  input  logic                 regwrite_m,
  input  logic [1:0]           result_src_m,
  input  logic [2:0]           funct3_m,
  input  logic [4:0]           rd_m,
  input  logic [XLEN-1:0]      alu_result_m,
  input  logic [XLEN-1:0]      read_data_m,
  input  logic [XLEN-1:0]      pc_plus_4_m,
  input  logic                 stall_w,
  input  logic                 flush_w,
  output logic                 writeback_control,
  output logic [4:0]           writeback_rd,
  output logic [XLEN-1:0]      writeback_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 load_misaligned,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic [CNT_WIDTH-1:0] misalign_count
);

  memwb_t               memwb_q, memwb_d;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;
  logic [CNT_WIDTH-1:0] misal_q, misal_d;
  logic [XLEN-1:0]      load_data;
  logic                 align_mis;
  logic                 departs;

  // Flush wins over stall; a flushed slot is an all-zero bubble.
  always_comb begin
    memwb_d = memwb_q;
    if (flush_w) begin
      memwb_d = '0;
    end else if (!stall_w) begin
      memwb_d.valid      = valid_m;
      memwb_d.regwrite   = regwrite_m;
      memwb_d.result_src = result_src_m;
      memwb_d.funct3     = funct3_m;
      memwb_d.rd         = rd_m;
      memwb_d.alu_result = alu_result_m;
      memwb_d.read_data  = read_data_m;
      memwb_d.pc_plus_4  = pc_plus_4_m;
    end
  end

  load_align u_load_align (
    .funct3_i     (memwb_q.funct3),
    .addr_i       (memwb_q.alu_result[1:0]),
    .word_i       (memwb_q.read_data),
    .data_o       (load_data),
    .misaligned_o (align_mis)
  );

  assign load_misaligned = memwb_q.valid && (memwb_q.result_src == RESULT_MEM) && align_mis;

  always_comb begin
    writeback_data = memwb_q.alu_result;
    case (memwb_q.result_src)
      RESULT_MEM: writeback_data = load_data;
      RESULT_PC4: writeback_data = memwb_q.pc_plus_4;
      default:    writeback_data = memwb_q.alu_result;
    endcase
  end

  assign writeback_control = memwb_q.valid && memwb_q.regwrite &&
                             (memwb_q.rd != 5'd0) && !load_misaligned;
  assign writeback_rd      = memwb_q.rd;

  assign fwd_valid = writeback_control;
  assign fwd_rd    = writeback_rd;
  assign fwd_data  = writeback_data;

  // An instruction counts once, on the edge it leaves WB; flush does not cancel it.
  assign departs = memwb_q.valid && !stall_w;

  always_comb begin
    retire_d = retire_q;
    misal_d  = misal_q;
    if (departs) begin
      if (load_misaligned) misal_d  = misal_q + CNT_WIDTH'(1);
      else                 retire_d = retire_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memwb_q  <= '0;
      retire_q <= '0;
      misal_q  <= '0;
    end else begin
      memwb_q  <= memwb_d;
      retire_q <= retire_d;
      misal_q  <= misal_d;
    end
  end

  assign retire_count   = retire_q;
  assign misalign_count = misal_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load/JAL results, misalignment,
// x0 suppression, stall/flush and asynchronous reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, regwrite_m, stall_w, flush_w;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus_4_m;
  logic        writeback_control, fwd_valid, load_misaligned;
  logic [4:0]  writeback_rd, fwd_rd;
  logic [31:0] writeback_data, fwd_data, retire_count, misalign_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = 0;
  logic [31:0] exp_mis = 0;

  wb_stage #(.CNT_WIDTH(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .regwrite_m(regwrite_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
    .stall_w(stall_w), .flush_w(flush_w),
    .writeback_control(writeback_control), .writeback_rd(writeback_rd),
    .writeback_data(writeback_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .load_misaligned(load_misaligned),
    .retire_count(retire_count), .misalign_count(misalign_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m = v; regwrite_m = rw; result_src_m = src; funct3_m = f3;
    rd_m = rd; alu_result_m = alu; read_data_m = rdata; pc_plus_4_m = pc4;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    reset = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'hAAAA, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({writeback_control, fwd_valid, load_misaligned, writeback_rd, writeback_data} !== 40'd0) begin
      errors++;
      $display("FAIL reset_hold: ctrl=%b fwd=%b mis=%b rd=%0d data=%h, want all 0",
               writeback_control, fwd_valid, load_misaligned, writeback_rd, writeback_data);
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (writeback_control !== 1'b0 || writeback_data !== 32'h0 || retire_count !== 32'h0 || misalign_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: ctrl=%b data=%h ret=%0d mis=%0d, want 0",
               writeback_control, writeback_data, retire_count, misalign_count);
    end
  endtask

  task automatic test_alu;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'hDEAD_BEEF, 32'h44);
    tick();
    checks++;
    if (writeback_control !== 1'b1 || writeback_rd !== 5'd5 || writeback_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_result: ctrl=%b rd=%0d data=%h, want 1 5 00001234",
               writeback_control, writeback_rd, writeback_data);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_fwd: fwd=%b rd=%0d data=%h, want 1 5 00001234", fwd_valid, fwd_rd, fwd_data);
    end
    checks++;
    if (retire_count !== 32'd0) begin
      errors++;
      $display("FAIL alu_ret_before: got %0d want 0", retire_count);
    end
    idle();
    tick();
    exp_ret = 1;
    checks++;
    if (retire_count !== exp_ret || writeback_control !== 1'b0) begin
      errors++;
      $display("FAIL alu_ret_after: ret=%0d ctrl=%b, want %0d 0", retire_count, writeback_control, exp_ret);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3   [5];
    logic [31:0] addr [5];
    logic [31:0] want [5];
    f3[0] = 3'b000; addr[0] = 32'h103; want[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; addr[1] = 32'h103; want[1] = 32'h0000_0080;
    f3[2] = 3'b001; addr[2] = 32'h102; want[2] = 32'hFFFF_80FF;
    f3[3] = 3'b101; addr[3] = 32'h100; want[3] = 32'h0000_7F01;
    f3[4] = 3'b010; addr[4] = 32'h100; want[4] = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b01, f3[i], 5'd10, addr[i], 32'h80FF_7F01, 32'h0);
      tick();
      if (i > 0) exp_ret++;
      checks++;
      if (writeback_data !== want[i] || writeback_control !== 1'b1 || load_misaligned !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: data=%h ctrl=%b mis=%b, want %h 1 0",
                 i, writeback_data, writeback_control, load_misaligned, want[i]);
      end
    end
    idle();
    tick();
    exp_ret++;
    checks++;
    if (retire_count !== exp_ret) begin
      errors++;
      $display("FAIL load_retire: got %0d want %0d", retire_count, exp_ret);
    end
  endtask

  task automatic test_misaligned;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd3, 32'h101, 32'h1122_3344, 32'h0);
    tick();
    checks++;
    if (load_misaligned !== 1'b1 || writeback_control !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_misaligned: mis=%b ctrl=%b fwd=%b, want 1 0 0", load_misaligned, writeback_control, fwd_valid);
    end
    drive(1'b1, 1'b1, 2'b01, 3'b101, 5'd4, 32'h203, 32'h1122_3344, 32'h0);
    tick();
    exp_mis++;
    checks++;
    if (load_misaligned !== 1'b1 || misalign_count !== exp_mis || retire_count !== exp_ret) begin
      errors++;
      $display("FAIL lhu_misaligned: mis=%b mcnt=%0d ret=%0d, want 1 %0d %0d",
               load_misaligned, misalign_count, retire_count, exp_mis, exp_ret);
    end
    idle();
    tick();
    exp_mis++;
    checks++;
    if (misalign_count !== exp_mis || retire_count !== exp_ret) begin
      errors++;
      $display("FAIL misalign_count: mcnt=%0d ret=%0d, want %0d %0d", misalign_count, retire_count, exp_mis, exp_ret);
    end
  endtask

  task automatic test_jal_x0;
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'hDEAD_0000, 32'h0, 32'h2004);
    tick();
    checks++;
    if (writeback_data !== 32'h0000_2004 || writeback_control !== 1'b1 || writeback_rd !== 5'd1) begin
      errors++;
      $display("FAIL jal_link: data=%h ctrl=%b rd=%0d, want 00002004 1 1", writeback_data, writeback_control, writeback_rd);
    end
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 32'hDEAD_0000, 32'h0, 32'h2004);
    tick();
    exp_ret++;
    checks++;
    if (writeback_control !== 1'b0 || writeback_data !== 32'h0000_2004) begin
      errors++;
      $display("FAIL x0_suppress: ctrl=%b data=%h, want 0 00002004", writeback_control, writeback_data);
    end
    idle();
    tick();
    exp_ret++;
    checks++;
    if (retire_count !== exp_ret) begin
      errors++;
      $display("FAIL x0_retire: got %0d want %0d", retire_count, exp_ret);
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'h77, 32'h0, 32'h0);
    tick();
    stall_w = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd9, 32'h99, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (writeback_rd !== 5'd7 || writeback_data !== 32'h77 || writeback_control !== 1'b1 || retire_count !== exp_ret) begin
        errors++;
        $display("FAIL stall_hold_%0d: rd=%0d data=%h ctrl=%b ret=%0d, want 7 00000077 1 %0d",
                 i, writeback_rd, writeback_data, writeback_control, retire_count, exp_ret);
      end
    end
    stall_w = 1'b0;
    tick();
    exp_ret++;
    checks++;
    if (writeback_rd !== 5'd9 || writeback_data !== 32'h99 || retire_count !== exp_ret) begin
      errors++;
      $display("FAIL stall_release: rd=%0d data=%h ret=%0d, want 9 00000099 %0d",
               writeback_rd, writeback_data, retire_count, exp_ret);
    end
    // Flush alone: the departing instruction still counts.
    flush_w = 1'b1;
    tick();
    exp_ret++;
    checks++;
    if (writeback_control !== 1'b0 || writeback_rd !== 5'd0 || writeback_data !== 32'h0 || retire_count !== exp_ret) begin
      errors++;
      $display("FAIL flush_bubble: ctrl=%b rd=%0d data=%h ret=%0d, want 0 0 0 %0d",
               writeback_control, writeback_rd, writeback_data, retire_count, exp_ret);
    end
    flush_w = 1'b0;
    tick();
    flush_w = 1'b1; stall_w = 1'b1;
    tick();
    checks++;
    if (writeback_control !== 1'b0 || writeback_rd !== 5'd0 || writeback_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_over_stall: ctrl=%b rd=%0d data=%h, want 0 0 0", writeback_control, writeback_rd, writeback_data);
    end
    flush_w = 1'b0; stall_w = 1'b0;
    idle();
    tick();
    checks++;
    if (retire_count !== exp_ret || misalign_count !== exp_mis) begin
      errors++;
      $display("FAIL bubble_no_count: ret=%0d mcnt=%0d, want %0d %0d", retire_count, misalign_count, exp_ret, exp_mis);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h5555, 32'h0, 32'h0);
    tick();
    checks++;
    if (writeback_control !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: ctrl=%b want 1", writeback_control);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (writeback_control !== 1'b0 || fwd_valid !== 1'b0 || retire_count !== 32'd0 || misalign_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b fwd=%b ret=%0d mcnt=%0d, want 0 0 0 0",
               writeback_control, fwd_valid, retire_count, misalign_count);
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misaligned();
    test_jal_x0();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
